// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - scancodes, state encoding and decode fields for PS/2 number entry
package ps2_key_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Element i holds the set-2 make code for decimal digit i.
  localparam logic [9:0][7:0] SC_DIGIT_MAIN = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                               8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [9:0][7:0] SC_DIGIT_PAD  = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                               8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_CONV  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_enter;
    logic       is_bksp;
    logic       is_esc;
  } key_dec_t;

endpackage

// File: rtl/ps2_scancode_decode.sv
// rtl/ps2_scancode_decode.sv - combinational classification of a set-2 make code
module ps2_scancode_decode
  import ps2_key_pkg::*;
(
  input  logic [7:0] scancode,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_enter,
  output logic       is_bksp,
  output logic       is_esc
);

  key_dec_t dec;

  always_comb begin
    dec = '0;
    for (int i = 0; i < 10; i++) begin
      if (scancode == SC_DIGIT_MAIN[i] || scancode == SC_DIGIT_PAD[i]) begin
        dec.is_digit = 1'b1;
        dec.digit    = 4'(i);
      end
    end
    dec.is_enter = (scancode == SC_ENTER);
    dec.is_bksp  = (scancode == SC_BKSP);
    dec.is_esc   = (scancode == SC_ESC);
  end

  assign is_digit = dec.is_digit;
  assign digit    = dec.digit;
  assign is_enter = dec.is_enter;
  assign is_bksp  = dec.is_bksp;
  assign is_esc   = dec.is_esc;

endmodule

// File: rtl/ps2_num_entry_ctrl.sv
// rtl/ps2_num_entry_ctrl.sv - PS/2 decimal entry, BCD-to-binary conversion and MMIO handshake
module ps2_num_entry_ctrl
  import ps2_key_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              scancode,
  input  logic                    key_pressed,
  input  logic                    key_released,
  input  logic                    value_ack,
  output logic [VAL_W-1:0]        value,
  output logic                    value_valid,
  output logic [4*MAX_DIGITS-1:0] bcd,
  output logic [3:0]              digit_cnt,
  output logic                    busy,
  output logic                    key_rejected
);

  localparam int         BCD_W   = 4 * MAX_DIGITS;
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [2:0]       idx_q, idx_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             rej_q, rej_d;
  logic             lock_q, lock_d;
  logic [7:0]       last_sc_q, last_sc_d;

  logic             is_digit, is_enter, is_bksp, is_esc;
  logic [3:0]       digit;
  logic             lock_eff, press_live;
  logic [3:0]       digit_sel;
  logic [3:0]       cnt_m1;
  logic [VAL_W-1:0] acc_mul;
  logic [BCD_W-1:0] bcd_shl;

  ps2_scancode_decode u_decode (
    .scancode (scancode),
    .is_digit (is_digit),
    .digit    (digit),
    .is_enter (is_enter),
    .is_bksp  (is_bksp),
    .is_esc   (is_esc)
  );

  // A release in the same cycle unlocks before the press is judged.
  assign lock_eff   = lock_q & ~key_released;
  assign press_live = key_pressed & ~(lock_eff & (scancode == last_sc_q));
  assign cnt_m1     = cnt_q - 4'd1;
  assign bcd_shl    = (bcd_q << 4) | {{(BCD_W-4){1'b0}}, digit};

  always_comb begin
    digit_sel = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx_q == 3'(i)) digit_sel = bcd_q[4*i +: 4];
    end
  end

  assign acc_mul = (acc_q << 3) + (acc_q << 1) + {{(VAL_W-4){1'b0}}, digit_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      rej_q     <= 1'b0;
      lock_q    <= 1'b0;
      last_sc_q <= '0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      rej_q     <= rej_d;
      lock_q    <= lock_d;
      last_sc_q <= last_sc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    value_d   = value_q;
    valid_d   = valid_q;
    rej_d     = 1'b0;
    lock_d    = lock_eff;
    last_sc_d = last_sc_q;

    if (press_live) begin
      lock_d    = 1'b1;
      last_sc_d = scancode;
    end

    case (state_q)
      ST_IDLE: begin
        if (press_live && is_digit) begin
          bcd_d   = bcd_shl;
          cnt_d   = 4'd1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (press_live) begin
          if (is_digit) begin
            if (cnt_q < MAX_CNT) begin
              bcd_d = bcd_shl;
              cnt_d = cnt_q + 4'd1;
            end else begin
              rej_d = 1'b1;
            end
          end else if (is_bksp) begin
            bcd_d = bcd_q >> 4;
            cnt_d = cnt_m1;
            if (cnt_m1 == 4'd0) state_d = ST_IDLE;
          end else if (is_esc) begin
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (is_enter) begin
            acc_d   = '0;
            idx_d   = cnt_m1[2:0];
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        rej_d = press_live;
        acc_d = acc_mul;
        if (idx_q == 3'd0) begin
          value_d = acc_mul;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      default: begin
        rej_d = press_live;
        if (value_ack) begin
          valid_d = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    value        = value_q;
    value_valid  = valid_q;
    bcd          = bcd_q;
    digit_cnt    = cnt_q;
    busy         = (state_q == ST_CONV) || (state_q == ST_HOLD);
    key_rejected = rej_q;
  end

endmodule

// File: tb/tb_ps2_num_entry_ctrl.sv
// tb/tb_ps2_num_entry_ctrl.sv - directed bench with a digit-queue reference model
module tb_ps2_num_entry_ctrl;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  scancode = 8'h00;
  logic        key_pressed = 1'b0;
  logic        key_released = 1'b0;
  logic        value_ack = 1'b0;
  logic [13:0] value;
  logic        value_valid;
  logic [15:0] bcd;
  logic [3:0]  digit_cnt;
  logic        busy;
  logic        key_rejected;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int         m_digits[$];
  int         m_mode = 0;
  int         m_value = 0;
  bit         m_valid = 1'b0;
  int         m_conv_left = 0;
  int         m_pending = 0;
  bit         m_lock = 1'b0;
  logic [7:0] m_last = 8'h00;
  bit         m_rej = 1'b0;

  logic [7:0] main_t [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pad_t  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  ps2_num_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .scancode     (scancode),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .value_ack    (value_ack),
    .value        (value),
    .value_valid  (value_valid),
    .bcd          (bcd),
    .digit_cnt    (digit_cnt),
    .busy         (busy),
    .key_rejected (key_rejected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 other, 1 digit, 2 enter, 3 backspace, 4 escape
  task automatic decode(input logic [7:0] s, output int kind, output int d);
    kind = 0;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (s == main_t[i] || s == pad_t[i]) begin
        kind = 1;
        d = i;
      end
    end
    if (s == 8'h5A) kind = 2;
    if (s == 8'h66) kind = 3;
    if (s == 8'h76) kind = 4;
  endtask

  function automatic logic [15:0] model_bcd();
    logic [15:0] b;
    int n;
    b = 16'h0;
    n = m_digits.size();
    for (int i = 0; i < n; i++) b[4*i +: 4] = 4'(m_digits[n-1-i]);
    return b;
  endfunction

  task automatic model_step(input bit kp, input logic [7:0] sc, input bit kr, input bit ack, input bit r);
    int kind;
    int d;
    bit live;
    if (r) begin
      m_digits.delete();
      m_mode = 0; m_value = 0; m_valid = 1'b0; m_lock = 1'b0;
      m_last = 8'h00; m_rej = 1'b0; m_conv_left = 0;
      return;
    end
    m_rej = 1'b0;
    if (kr) m_lock = 1'b0;
    live = kp && !(m_lock && sc == m_last);
    if (live) begin
      m_lock = 1'b1;
      m_last = sc;
    end
    decode(sc, kind, d);
    case (m_mode)
      0: if (live && kind == 1) begin
           m_digits.push_back(d);
           m_mode = 1;
         end
      1: if (live) begin
           if (kind == 1) begin
             if (m_digits.size() < MAXD) m_digits.push_back(d);
             else m_rej = 1'b1;
           end else if (kind == 3) begin
             m_digits.delete(m_digits.size() - 1);
             if (m_digits.size() == 0) m_mode = 0;
           end else if (kind == 4) begin
             m_digits.delete();
             m_mode = 0;
           end else if (kind == 2) begin
             m_pending = 0;
             foreach (m_digits[i]) m_pending = m_pending * 10 + m_digits[i];
             m_conv_left = m_digits.size();
             m_mode = 2;
           end
         end
      2: begin
           if (live) m_rej = 1'b1;
           m_conv_left--;
           if (m_conv_left == 0) begin
             m_value = m_pending;
             m_valid = 1'b1;
             m_mode = 3;
           end
         end
      default: begin
           if (live) m_rej = 1'b1;
           if (ack) begin
             m_valid = 1'b0;
             m_digits.delete();
             m_mode = 0;
           end
         end
    endcase
  endtask

  task automatic cyc(input bit kp, input logic [7:0] sc, input bit kr, input bit ack, input bit r);
    key_pressed = kp;
    scancode = sc;
    key_released = kr;
    value_ack = ack;
    rst = r;
    @(posedge clk);
    model_step(kp, sc, kr, ack, r);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rel();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tap(input logic [7:0] sc);
    cyc(1'b1, sc, 1'b0, 1'b0, 1'b0);
    rel();
  endtask

  task automatic enter_and_wait(output int k);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    k = 1;
    while (!value_valid && k < 20) begin
      idle();
      k++;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("value", 32'(value), 32'(m_value));
      chk("value_valid", 32'(value_valid), 32'(m_valid));
      chk("bcd", 32'(bcd), 32'(model_bcd()));
      chk("digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
      chk("busy", 32'(busy), 32'(m_mode >= 2));
      chk("key_rejected", 32'(key_rejected), 32'(m_rej));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_valid", 32'(value_valid), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    idle();

    tap(8'h16); tap(8'h1E); tap(8'h26);
    chk("t1_bcd", 32'(bcd), 32'h0123);
    chk("t1_cnt", 32'(digit_cnt), 32'd3);
    enter_and_wait(k);
    chk("t1_latency", 32'(k), 32'd4);
    chk("t1_value", 32'(value), 32'd123);
    chk("t1_busy", 32'(busy), 32'd1);
    rel();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_ack_valid", 32'(value_valid), 32'd0);
    chk("t1_ack_bcd", 32'(bcd), 32'd0);
    chk("t1_ack_busy", 32'(busy), 32'd0);
    chk("t1_value_kept", 32'(value), 32'd123);

    tap(8'h46); tap(8'h3E); tap(8'h3D); tap(8'h36);
    cyc(1'b1, 8'h2E, 1'b0, 1'b0, 1'b0);
    chk("t2_reject", 32'(key_rejected), 32'd1);
    chk("t2_bcd", 32'(bcd), 32'h9876);
    rel();
    enter_and_wait(k);
    chk("t2_latency", 32'(k), 32'd5);
    chk("t2_value", 32'(value), 32'd9876);
    rel();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    tap(8'h25);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tap(8'h1C);
    tap(8'h2E); tap(8'h66); tap(8'h3D);
    chk("t3_bcd", 32'(bcd), 32'h0047);
    enter_and_wait(k);
    chk("t3_value", 32'(value), 32'd47);
    rel();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tap(8'h25); tap(8'h76); tap(8'h5A);
    idle(); idle(); idle();
    chk("t3_esc_valid", 32'(value_valid), 32'd0);
    chk("t3_esc_busy", 32'(busy), 32'd0);
    chk("t3_esc_cnt", 32'(digit_cnt), 32'd0);

    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0); idle();
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0); idle();
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
    rel();
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
    rel();
    chk("t4_bcd", 32'(bcd), 32'h0011);
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h16, 1'b1, 1'b0, 1'b0);
    rel();
    chk("t4_same_cycle_bcd", 32'(bcd), 32'h1111);
    chk("t4_same_cycle_cnt", 32'(digit_cnt), 32'd4);
    tap(8'h76);

    tap(8'h73);
    enter_and_wait(k);
    chk("t5_latency", 32'(k), 32'd2);
    chk("t5_value", 32'(value), 32'd5);
    rel();
    cyc(1'b1, 8'h45, 1'b0, 1'b1, 1'b0);
    chk("t5_reject", 32'(key_rejected), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_bcd", 32'(bcd), 32'd0);
    chk("t5_valid", 32'(value_valid), 32'd0);
    rel();

    tap(8'h16); tap(8'h1E); tap(8'h26); tap(8'h25);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t6_in_conv", 32'(busy), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_value", 32'(value), 32'd0);
    chk("t6_rst_valid", 32'(value_valid), 32'd0);
    chk("t6_rst_bcd", 32'(bcd), 32'd0);
    chk("t6_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    idle();
    tap(8'h45);
    enter_and_wait(k);
    chk("t6_latency", 32'(k), 32'd2);
    chk("t6_valid", 32'(value_valid), 32'd1);
    chk("t6_value", 32'(value), 32'd0);
    rel();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
